// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes and wait timeout
module multicycle_ctrl #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        jump,
  output logic        beq,
  output logic        bne,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        fault,
  output logic [15:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d, wait_q, wait_d;
  logic [15:0] retired_q, retired_d;
  logic is_lw, is_sw, is_r, is_br, is_j, illegal;
  assign is_lw = op_q == 4'd0;
  assign is_sw = op_q == 4'd1;
  assign is_r = op_q >= 4'd2 && op_q <= 4'd9;
  assign is_br = op_q == 4'd11 || op_q == 4'd12;
  assign is_j = op_q == 4'd13;
  assign illegal = opcode == 4'd10 || opcode >= 4'd14;
  assign retired = retired_q;
  always_comb begin
    {imem_req, dmem_req, ir_write, pc_write, jump, beq, bne, mem_read, mem_write} = '0;
    {alu_src, reg_dst, mem_to_reg, reg_write, alu_op} = '0;
    busy = state_q != IDLE && state_q != FAULT;
    fault = state_q == FAULT;
    state_d = state_q;
    wait_d = wait_q;
    retired_d = retired_q;
    op_d = state_q == DECODE ? opcode : op_q;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        state_d = imem_ready ? DECODE : wait_q == WAIT_LAST ? FAULT : FETCH;
        wait_d = wait_q + 4'd1;
      end
      DECODE: state_d = illegal ? FAULT : EXEC;
      EXEC: begin
        alu_op = is_br ? 2'b01 : (is_lw || is_sw) ? 2'b10 : 2'b00;
        alu_src = is_lw || is_sw;
        reg_dst = is_r;
        beq = op_q == 4'd11;
        bne = op_q == 4'd12;
        jump = is_j;
        pc_write = is_br || is_j;
        state_d = is_r ? WB : MEM;
      end
      MEM: begin
        alu_op = 2'b10;
        alu_src = 1'b1;
        dmem_req = 1'b1;
        mem_read = is_lw;
        mem_write = is_sw;
        pc_write = dmem_ready && is_sw;
        state_d = dmem_ready ? WB : wait_q == WAIT_LAST ? FAULT : MEM;
        wait_d = wait_q + 4'd1;
      end
      WB: begin
        reg_write = 1'b1;
        pc_write = 1'b1;
        mem_to_reg = is_lw;
        alu_src = is_lw;
        alu_op = is_lw ? 2'b10 : 2'b00;
        reg_dst = is_r;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (pc_write) begin
      state_d = run ? FETCH : IDLE;
      retired_d = retired_q + 16'd1;
    end
    if (state_d != state_q) wait_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      wait_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      wait_q <= wait_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: phase-level reference model of the sequencer checked every cycle, plus literal pins
module tb_multicycle_ctrl;
  logic clk = 0, reset = 1, run = 0, imem_ready = 0, dmem_ready = 0;
  logic [3:0] opcode = 0;
  logic imem_req, dmem_req, ir_write, pc_write, jump, beq, bne, mem_read, mem_write;
  logic alu_src, reg_dst, mem_to_reg, reg_write, busy, fault;
  logic [1:0] alu_op;
  logic [15:0] retired;
  multicycle_ctrl #(.WAIT_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
    .jump(jump), .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_op(alu_op), .busy(busy), .fault(fault), .retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic imem_req, dmem_req, ir_write, pc_write, jump, beq, bne, mem_read, mem_write;
    logic alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_op;
    logic busy, fault;
  } ov_t;
  typedef enum {P_IDLE, P_FW, P_FR, P_DEC, P_EX, P_MW, P_MR, P_WB, P_FLT} ph_t;
  ov_t act, exp_v;
  assign act = {imem_req, dmem_req, ir_write, pc_write, jump, beq, bne, mem_read, mem_write,
                alu_src, reg_dst, mem_to_reg, reg_write, alu_op, busy, fault};
  logic [15:0] exp_ret = 0;
  bit chk_en = 0;
  int n_cmp = 0, n_bad = 0, cnt_pc = 0, cnt_rw = 0, cnt_busy = 0, cnt_mr = 0;

  // Expected controls for one cycle, from the instruction class and the phase it is in
  function automatic ov_t model(ph_t p, logic [3:0] op);
    ov_t o = '0;
    bit lw = op == 0, sw = op == 1, r = op >= 2 && op <= 9;
    bit bq = op == 11, bn = op == 12, j = op == 13;
    case (p)
      P_FW: o.imem_req = 1;
      P_FR: begin o.imem_req = 1; o.ir_write = 1; end
      P_EX: begin
        o.alu_op = (bq || bn) ? 2'b01 : (lw || sw) ? 2'b10 : 2'b00;
        o.reg_dst = r; o.alu_src = lw || sw;
        o.beq = bq; o.bne = bn; o.jump = j; o.pc_write = bq || bn || j;
      end
      P_MW, P_MR: begin
        o.alu_op = 2'b10; o.alu_src = 1; o.dmem_req = 1;
        o.mem_read = lw; o.mem_write = sw; o.pc_write = p == P_MR && sw;
      end
      P_WB: begin
        o.reg_write = 1; o.pc_write = 1; o.mem_to_reg = lw; o.alu_src = lw;
        o.alu_op = lw ? 2'b10 : 2'b00; o.reg_dst = r;
      end
      P_FLT: o.fault = 1;
      default: ;
    endcase
    o.busy = !(p == P_IDLE || p == P_FLT);
    return o;
  endfunction

  always @(negedge clk) if (chk_en) begin
    n_cmp++;
    if (act !== exp_v || retired !== exp_ret) begin
      n_bad++;
      $display("FAIL cycle@%0t ctrl actual=%h required=%h retired actual=%h required=%h",
               $time, act, exp_v, retired, exp_ret);
    end
    cnt_pc += int'(pc_write); cnt_rw += int'(reg_write);
    cnt_busy += int'(busy); cnt_mr += int'(mem_read);
  end

  task automatic chk(string nm, int a, int e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, a, e);
    end
  endtask

  task automatic step(ph_t p, logic [3:0] op, logic ir, logic dr, logic rn, logic rs = 0);
    imem_ready = ir; dmem_ready = dr; run = rn; opcode = op; reset = rs;
    exp_v = model(p, op);
    @(posedge clk);
    if (rs) exp_ret = 0;
    else if (exp_v.pc_write) exp_ret++;
    #1;
  endtask

  task automatic instr(logic [3:0] op, int iw, int dw, logic rn);
    for (int k = 0; k < iw; k++) step(P_FW, op, 0, 0, 1);
    step(P_FR, op, 1, 1, 1);
    step(P_DEC, op, 1, 1, 1);
    if (op == 10 || op >= 14) return;
    if (op <= 1) begin
      step(P_EX, op, 1, 1, 1);
      for (int k = 0; k < dw; k++) step(P_MW, op, 1, 0, 1);
      if (op == 1) step(P_MR, op, 1, 1, rn);
      else begin step(P_MR, op, 1, 1, 1); step(P_WB, op, 1, 1, rn); end
    end else if (op <= 9) begin
      step(P_EX, op, 1, 1, 1);
      step(P_WB, op, 1, 1, rn);
    end else step(P_EX, op, 1, 1, rn);
  endtask

  task automatic do_rst(ph_t p, logic [3:0] op);
    step(p, op, 1, 0, 0, 1);
    step(P_IDLE, 0, 0, 0, 0, 1);
    step(P_IDLE, 0, 0, 0, 0);
  endtask

  task automatic zero_cnt();
    cnt_pc = 0; cnt_rw = 0; cnt_busy = 0; cnt_mr = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    exp_ret = 0; chk_en = 1;
    step(P_IDLE, 0, 0, 0, 0, 1);
    step(P_IDLE, 0, 0, 0, 0);
    step(P_IDLE, 0, 0, 0, 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_retired", int'(retired), 0);
    // mixed zero-wait sequence: 4+5+4+3+3 cycles
    step(P_IDLE, 0, 1, 1, 1);
    zero_cnt();
    instr(4'd2, 0, 0, 1);
    instr(4'd0, 0, 0, 1);
    instr(4'd1, 0, 0, 1);
    instr(4'd11, 0, 0, 1);
    instr(4'd13, 0, 0, 0);
    chk("mixed_pc_writes", cnt_pc, 5);
    chk("mixed_reg_writes", cnt_rw, 2);
    chk("mixed_cycles", cnt_busy, 19);
    chk("mixed_retired", int'(retired), 5);
    step(P_IDLE, 0, 1, 1, 0);
    // LW with three data wait cycles
    step(P_IDLE, 0, 1, 1, 1);
    zero_cnt();
    instr(4'd0, 0, 3, 0);
    chk("lw_wait_mem_read", cnt_mr, 4);
    chk("lw_wait_cycles", cnt_busy, 8);
    chk("lw_wait_reg_write", cnt_rw, 1);
    // fetch ready on the last allowed wait cycle wins over the timeout
    step(P_IDLE, 0, 1, 1, 1);
    instr(4'd13, 14, 0, 0);
    chk("late_ready_fault", int'(fault), 0);
    chk("late_ready_retired", int'(retired), 7);
    // illegal opcode
    step(P_IDLE, 0, 1, 1, 1);
    zero_cnt();
    instr(4'd14, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(P_FLT, 14, 1, 1, 1);
    chk("illegal_pc_writes", cnt_pc, 0);
    chk("illegal_fault", int'(fault), 1);
    chk("illegal_retired_frozen", int'(retired), 7);
    do_rst(P_FLT, 14);
    chk("illegal_reset_fault", int'(fault), 0);
    // instruction fetch timeout
    step(P_IDLE, 0, 0, 0, 1);
    for (int k = 0; k < 15; k++) step(P_FW, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(P_FLT, 0, 1, 1, 1);
    chk("timeout_fault", int'(fault), 1);
    do_rst(P_FLT, 0);
    chk("timeout_reset_fault", int'(fault), 0);
    // reset in the middle of a stalled SW
    step(P_IDLE, 0, 1, 1, 1);
    step(P_FR, 1, 1, 1, 1);
    step(P_DEC, 1, 1, 1, 1);
    step(P_EX, 1, 1, 0, 1);
    step(P_MW, 1, 1, 0, 1);
    do_rst(P_MW, 1);
    chk("midreset_mem_write", int'(mem_write), 0);
    chk("midreset_retired", int'(retired), 0);
    // retire counter wrap
    force dut.retired_q = 16'hFFFF;
    exp_ret = 16'hFFFF;
    #1 release dut.retired_q;
    step(P_IDLE, 0, 1, 1, 1);
    instr(4'd13, 0, 0, 0);
    chk("wrap_retired", int'(retired), 0);
    step(P_IDLE, 0, 1, 1, 0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 16-bit datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives all datapath control lines from the 4-bit opcode. It also drives the PC and instruction-register write enables and handshakes variable-latency instruction and data memories. It sits between the memories and the datapath, replacing the single-cycle combinational control and letting one ALU/memory path be reused across cycles.

## Interface
- `WAIT_TIMEOUT`, 15: number of consecutive cycles a memory request may wait for ready before the block faults (1..15; 4-bit wait counter).
- `clk`  in  1  : system clock; all state updates on the rising edge.
- `reset`  in  1  : synchronous, active-high reset.
- `run`  in  1  : start/continue; sampled in IDLE and at each retire.
- `opcode`  in  4  : instr[15:12] from the instruction register.
- `imem_ready`  in  1  : instruction memory has valid data this cycle.
- `dmem_ready`  in  1  : data memory access completes this cycle.
- `imem_req`  out  1  : instruction fetch request.
- `dmem_req`  out  1  : data access request.
- `ir_write`  out  1  : load the instruction register.
- `pc_write`  out  1  : load PC from the datapath's next-PC.
- `jump`, `beq`, `bne`, `mem_read`, `mem_write`, `alu_src`, `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each : datapath controls.
- `alu_op`  out  2  : 00 = R-type, 01 = branch compare, 10 = address add.
- `busy`  out  1  : high in every state except IDLE and FAULT.
- `fault`  out  1  : sticky error flag.
- `retired`  out  16 : retired-instruction count.

## Operation
- **Opcode classes:**
  - 0000 LW
  - 0001 SW
  - 0010–1001 R-type
  - 1011 BEQ
  - 1100 BNE
  - 1101 J
  - 1010, 1110, 1111 are illegal.
- **State register:** IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- **Opcode latch:** `opcode` is latched into `op_q` on the DECODE edge. All outputs are decoded from the registered state and `op_q`; there is no combinational path from `opcode` to the outputs.
- **IDLE:** all outputs 0. `run`=1 → FETCH.
- **FETCH:** `imem_req`=1. While `imem_ready`=1, `ir_write`=1 and the next state is DECODE.
- **DECODE:** illegal `opcode` → FAULT; otherwise → EXEC.
- **EXEC:**
  - R-type: `alu_op`=00, `reg_dst`=1 → WB.
  - LW/SW: `alu_op`=10, `alu_src`=1 → MEM.
  - BEQ/BNE: `alu_op`=01, `beq`/`bne`=1, `pc_write`=1; retire.
  - J: `jump`=1, `pc_write`=1; retire.
- **MEM:** `alu_op`=10, `alu_src`=1 and `dmem_req`=1 held. `mem_read`=1 for LW; `mem_write`=1 for SW, held until `dmem_ready`. When `dmem_ready`=1:
  - LW → WB.
  - SW: `pc_write`=1; retire.
- **WB:** `reg_write`=1 for exactly one cycle and `pc_write`=1.
  - LW: `mem_to_reg`=1, `alu_src`=1, `alu_op`=10.
  - R-type: `reg_dst`=1, `alu_op`=00.
  - Retire.
- **Retire (the cycle `pc_write`=1):**
  - `retired` increments and wraps 0xFFFF → 0x0000.
  - Next state is FETCH if `run`=1, else IDLE.
- **Timeout:**
  - The wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - When it reaches `WAIT_TIMEOUT` with ready still low → FAULT.
  - Ready arriving in the same cycle the counter reaches `WAIT_TIMEOUT` wins (no fault).
- **FAULT:** `fault`=1, all other outputs 0, `retired` frozen. Only `reset` exits FAULT.
- **Reset (including mid-operation):**
  - State → IDLE; `retired`, `op_q`, wait counter and `fault` → 0.
  - All outputs 0 in the cycle after the reset edge; pending requests are dropped.
- `run` deasserting mid-instruction does not abort it; it takes effect only at retire.

## Timing
- Memory ready is sampled in the same cycle as the request. Ready high in the first FETCH/MEM cycle costs 1 cycle.
- Minimum cycles per instruction (zero-wait memories):
  - J/BEQ/BNE: 3 (FETCH, DECODE, EXEC)
  - R-type and SW: 4
  - LW: 5
- Each wait cycle adds 1.
- `pc_write`, `ir_write` and `reg_write` are single-cycle pulses. They never coincide, except that `pc_write` and `reg_write` coincide in WB.
- The branch decision uses the datapath zero flag during EXEC; the controller only asserts `beq`/`bne` and `pc_write` together.

## Test plan
- **Reset state:** reset held 2 cycles, then `run`=0 → all outputs 0, `busy`=0, `retired`=0; stays IDLE.
- **Mixed sequence, zero wait:** `run`=1, ready tied high; feed opcodes 0010, 0000, 0001, 1011, 1101.
  - Per-instruction cycles: 4, 5, 4, 3, 3.
  - Exactly one `pc_write` per instruction; `reg_write` only for 0010 and 0000.
  - `retired`=5 after 19 cycles.
- **LW with wait:** LW with `dmem_ready` low for 3 MEM cycles → `mem_read`/`dmem_req` held 4 cycles, then WB with `mem_to_reg`=1, `reg_write`=1; total 8 cycles.
- **Timeout:**
  - `imem_ready` stuck low with `WAIT_TIMEOUT`=15 → `fault`=1 after 15 waiting cycles; a later `imem_ready` does not clear it.
  - `reset` clears `fault` to 0.
- **Illegal opcode and mid-operation reset:**
  - Opcode 1110 → FAULT from DECODE, no `pc_write`.
  - Separately, `reset` asserted during MEM of SW → `mem_write` 0 the next cycle, `retired`=0.
- **Counter wrap:** `retired` preloaded to 0xFFFF via 65535 J instructions (or a forced value) → the next retire reads 0x0000.
